// File: rtl/mem_access_unit.sv
// Memory access stage between EX and WB: performs one load/store per op over a
// req/gnt/rvalid data port, or passes the ALU result straight through.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic [DATA_WIDTH-1:0]   store_data,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [2:0]              funct3,
    input  logic [4:0]              rd_in,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   wb_data,
    output logic [4:0]              rd_out,
    output logic                    misaligned,
    output logic                    bus_err,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDR_WIDTH-1:0]   dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    output logic [DATA_WIDTH/8-1:0] dmem_be,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int OFF_WIDTH = $clog2(BE_WIDTH);
    localparam int CNT_WIDTH = $clog2(MAX_WAIT);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                 state, state_next;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   we_q;
    logic [2:0]             funct3_q;
    logic [OFF_WIDTH-1:0]   off_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [BE_WIDTH-1:0]    be_q;
    logic [DATA_WIDTH-1:0]  wb_data_q;
    logic [4:0]             rd_q;
    logic                   misaligned_q;
    logic                   bus_err_q;

    logic                   is_mem;
    logic                   addr_misaligned;
    logic                   expired;
    logic [OFF_WIDTH-1:0]   off_in;
    logic [BE_WIDTH-1:0]    be_in;
    logic [DATA_WIDTH-1:0]  wdata_in;
    logic [DATA_WIDTH-1:0]  lane;
    logic [DATA_WIDTH-1:0]  load_data;
    logic                   ext_bit;

    // Request decode: alignment, byte enables and lane-replicated store data.
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        is_mem          = mem_read | mem_write;
        off_in          = alu_result[OFF_WIDTH-1:0];
        addr_misaligned = 1'b0;
        be_in           = '1;
        wdata_in        = store_data;
        case (funct3[1:0])
            2'b00: begin
                be_in    = BE_WIDTH'(1) << off_in;
                wdata_in = {BE_WIDTH{store_data[7:0]}};
            end
            2'b01: begin
                addr_misaligned = off_in[0];
                be_in           = BE_WIDTH'(3) << off_in;
                wdata_in        = {(BE_WIDTH/2){store_data[15:0]}};
            end
            default: addr_misaligned = (off_in != '0);
        endcase
        if (mem_read) be_in = '1;
    end

    // Load lane extraction; funct3[2] selects zero extension.
    always_comb begin
        lane      = dmem_rdata >> {off_q, 3'b000};
        load_data = lane;
        ext_bit   = 1'b0;
        case (funct3_q[1:0])
            2'b00: begin
                ext_bit   = lane[7] & ~funct3_q[2];
                load_data = {{(DATA_WIDTH-8){ext_bit}}, lane[7:0]};
            end
            2'b01: begin
                ext_bit   = lane[15] & ~funct3_q[2];
                load_data = {{(DATA_WIDTH-16){ext_bit}}, lane[15:0]};
            end
            default: load_data = lane;
        endcase
    end

    assign expired = (cnt == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = (!is_mem || addr_misaligned) ? RESP : REQ;
            REQ: begin
                if (dmem_gnt)     state_next = we_q ? RESP : WAIT;
                else if (expired) state_next = RESP;
            end
            WAIT: if (dmem_rvalid || expired) state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: operand registers are reset too, so outputs read as zero after reset rather than X.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            wb_data_q    <= '0;
            rd_q         <= '0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cnt          <= CNT_LOAD;
                    we_q         <= mem_write & ~mem_read;
                    funct3_q     <= funct3;
                    off_q        <= off_in;
                    addr_q       <= {alu_result[ADDR_WIDTH-1:OFF_WIDTH], OFF_WIDTH'(0)};
                    wdata_q      <= wdata_in;
                    be_q         <= be_in;
                    wb_data_q    <= is_mem ? '0 : alu_result;
                    rd_q         <= rd_in;
                    misaligned_q <= is_mem & addr_misaligned;
                    bus_err_q    <= 1'b0;
                end
                REQ: begin
                    cnt <= cnt - CNT_WIDTH'(1);
                    if (!dmem_gnt && expired) bus_err_q <= 1'b1;
                end
                WAIT: begin
                    cnt <= cnt - CNT_WIDTH'(1);
                    if (dmem_rvalid)  wb_data_q <= load_data;
                    else if (expired) bus_err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // dmem_req is gated by rst_n so a reset withdraws the request within the same cycle.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign dmem_req   = rst_n && (state == REQ);
    assign dmem_we    = (state == REQ) && we_q;
    assign dmem_addr  = (state == REQ) ? addr_q  : '0;
    assign dmem_wdata = (state == REQ) ? wdata_q : '0;
    assign dmem_be    = (state == REQ) ? be_q    : '0;
    assign wb_data    = wb_data_q;
    assign rd_out     = rd_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model of the load/store rules.
module tb_mem_access_unit;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] alu_result, store_data;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [4:0]  rd_in, rd_out;
    logic        resp_valid, resp_ready;
    logic [31:0] wb_data;
    logic        misaligned, bus_err;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .alu_result(alu_result), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .rd_in(rd_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .wb_data(wb_data), .rd_out(rd_out),
        .misaligned(misaligned), .bus_err(bus_err),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    // Reference: pick the addressed bytes arithmetically, then sign/zero extend.
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3);
        longint v, span;
        int     bits;
        bits = (f3[1:0] == 2'b00) ? 8 : (f3[1:0] == 2'b01) ? 16 : 32;
        span = longint'(1) << bits;
        v    = longint'({32'd0, word}) >> (8 * int'(off));
        v    = v % span;
        if (!f3[2] && bits < 32 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic scramble_inputs();
        alu_result = $urandom;
        store_data = $urandom;
        funct3     = 3'($urandom_range(0, 7));
        rd_in      = 5'($urandom_range(0, 31));
        mem_read   = 1'($urandom_range(0, 1));
        mem_write  = 1'($urandom_range(0, 1));
    endtask

    // One complete transaction, starting and ending on a falling edge with the unit idle.
    task automatic do_op(input string name, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rd_f, input logic wr_f,
                         input logic [2:0] f3, input int gnt_dly, input int rv_dly,
                         input logic [31:0] rdata, input int hold);
        logic        mem, load, mis, exp_bus, exp_we, req_bad, attr_bad, hold_bad;
        logic [1:0]  off;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_wb, exp_addr;
        int          g, r, exp_cycle, last_req, k;

        mem      = rd_f | wr_f;
        load     = rd_f;
        off      = addr[1:0];
        mis      = mem && ((f3[1:0] == 2'b01 && off[0]) || (f3[1] && off != 2'b00));
        exp_we   = wr_f && !rd_f;
        exp_addr = {addr[31:2], 2'b00};
        g        = gnt_dly + 1;
        r        = g + rv_dly;
        exp_bus  = 1'b0;
        if (!mem || mis)            exp_cycle = 1;
        else if (!load && g <= MAX_WAIT) exp_cycle = g + 1;
        else if (load && r <= MAX_WAIT)  exp_cycle = r + 1;
        else begin
            exp_cycle = MAX_WAIT + 1;
            exp_bus   = 1'b1;
        end
        last_req = (!mem || mis) ? 0 : ((g < MAX_WAIT) ? g : MAX_WAIT);
        if (!mem)                      exp_wb = addr;
        else if (mis || exp_bus || !load) exp_wb = 32'd0;
        else                           exp_wb = ref_load(rdata, off, f3);
        if (load)                  exp_be = 4'b1111;
        else if (f3[1:0] == 2'b00) exp_be = 4'b0001 << off;
        else if (f3[1:0] == 2'b01) exp_be = 4'b0011 << off;
        else                       exp_be = 4'b1111;
        if (f3[1:0] == 2'b00)      exp_wd = {24'd0, sd[7:0]} * 32'h0101_0101;
        else if (f3[1:0] == 2'b01) exp_wd = {16'd0, sd[15:0]} * 32'h0001_0001;
        else                       exp_wd = sd;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_at_accept: got %b required 1", name, req_ready);
        end
        req_valid = 1'b1; alu_result = addr; store_data = sd; rd_in = rd;
        mem_read = rd_f; mem_write = wr_f; funct3 = f3;
        resp_ready = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = rdata;
        @(negedge clk);
        req_valid = 1'b0;
        scramble_inputs();

        k = 1; req_bad = 1'b0; attr_bad = 1'b0;
        while (k <= 40 && resp_valid !== 1'b1) begin
            if (dmem_req !== (k <= last_req)) req_bad = 1'b1;
            if (k <= last_req && (dmem_addr !== exp_addr || dmem_be !== exp_be ||
                dmem_we !== exp_we || (exp_we && dmem_wdata !== exp_wd))) attr_bad = 1'b1;
            dmem_gnt    = (k == g);
            dmem_rvalid = load && (k == r);
            @(negedge clk);
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            k++;
        end

        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s resp_timeout: no resp_valid within 40 cycles, required at %0d", name, exp_cycle);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        if (k != exp_cycle) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles required %0d", name, k, exp_cycle);
        end
        checks++;
        if (req_bad) begin
            errors++;
            $display("FAIL %s dmem_req_pattern: got deviation, required high for cycles 1..%0d", name, last_req);
        end
        if (last_req > 0) begin
            checks++;
            if (attr_bad) begin
                errors++;
                $display("FAIL %s dmem_fields: got addr=%h be=%b we=%b wdata=%h required addr=%h be=%b we=%b wdata=%h",
                         name, dmem_addr, dmem_be, dmem_we, dmem_wdata, exp_addr, exp_be, exp_we, exp_wd);
            end
        end
        checks++;
        if (wb_data !== exp_wb) begin
            errors++;
            $display("FAIL %s wb_data: got %h required %h", name, wb_data, exp_wb);
        end
        checks++;
        if (rd_out !== rd) begin
            errors++;
            $display("FAIL %s rd_out: got %0d required %0d", name, rd_out, rd);
        end
        checks++;
        if (misaligned !== mis || bus_err !== exp_bus) begin
            errors++;
            $display("FAIL %s flags: got mis=%b err=%b required mis=%b err=%b", name, misaligned, bus_err, mis, exp_bus);
        end

        // Hold the response while throwing late gnt/rvalid and a new request at the unit.
        hold_bad = 1'b0;
        for (int h = 0; h < hold; h++) begin
            dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = $urandom;
            req_valid = 1'b1;
            scramble_inputs();
            @(negedge clk);
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || wb_data !== exp_wb ||
                rd_out !== rd || misaligned !== mis || bus_err !== exp_bus) hold_bad = 1'b1;
        end
        if (hold > 0) begin
            checks++;
            if (hold_bad) begin
                errors++;
                $display("FAIL %s hold_stable: got resp_valid=%b wb_data=%h required 1 and %h", name, resp_valid, wb_data, exp_wb);
            end
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got resp_valid=%b req_ready=%b required 0 and 1", name, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; resp_ready = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        scramble_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 ||
            dmem_be !== 4'd0 || dmem_addr !== 32'd0 || dmem_wdata !== 32'd0 || wb_data !== 32'd0 ||
            rd_out !== 5'd0 || misaligned !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b req=%b be=%b wb=%h rd=%0d required 1 0 0 0000 0 0",
                     req_ready, resp_valid, dmem_req, dmem_be, wb_data, rd_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op("passthru", 32'h0000_1234, 32'h0, 5'd3, 1'b0, 1'b0, 3'b010, 0, 1, 32'h0, 0);
        do_op("lb",       32'h0000_0103, 32'h0, 5'd4, 1'b1, 1'b0, 3'b000, 0, 2, 32'h80FF_FF00, 1);
        do_op("lbu",      32'h0000_0103, 32'h0, 5'd5, 1'b1, 1'b0, 3'b100, 0, 2, 32'h80FF_FF00, 0);
        do_op("sh",       32'h0000_0202, 32'h0000_ABCD, 5'd6, 1'b0, 1'b1, 3'b001, 3, 1, 32'h0, 2);
        do_op("lw_mis",   32'h0000_0101, 32'h0, 5'd7, 1'b1, 1'b0, 3'b010, 0, 1, 32'h0, 0);
        do_op("sh_mis",   32'h0000_0203, 32'h1111, 5'd8, 1'b0, 1'b1, 3'b001, 0, 1, 32'h0, 0);
        do_op("both_ld",  32'h0000_0302, 32'hFFFF, 5'd9, 1'b1, 1'b1, 3'b101, 1, 1, 32'h8001_7FFF, 0);
    endtask

    task automatic test_timeout();
        do_op("lw_tmo",   32'h0000_0400, 32'h0, 5'd10, 1'b1, 1'b0, 3'b010, 0, 100, 32'hDEAD_BEEF, 3);
        do_op("sw_tmo",   32'h0000_0404, 32'h5A5A_5A5A, 5'd11, 1'b0, 1'b1, 3'b010, 50, 1, 32'h0, 1);
        do_op("lw_edge",  32'h0000_0408, 32'h0, 5'd12, 1'b1, 1'b0, 3'b010, 4, 11, 32'h1357_9BDF, 0);
        do_op("sb_edge",  32'h0000_0409, 32'h77, 5'd13, 1'b0, 1'b1, 3'b000, 15, 1, 32'h0, 0);
    endtask

    task automatic test_reset_in_flight();
        // Reset while requesting: dmem_req falls in the same cycle.
        req_valid = 1'b1; alu_result = 32'h0000_0104; mem_read = 1'b1; mem_write = 1'b0;
        funct3 = 3'b010; rd_in = 5'd14;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_req_before: got dmem_req=%b required 1", dmem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req_drop: got dmem_req=%b required 0", dmem_req);
        end
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (req_ready !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_req_idle: got req_ready=%b dmem_req=%b required 1 and 0", req_ready, dmem_req);
        end

        // Reset while waiting for read data, with rvalid arriving in the same cycle.
        req_valid = 1'b1; alu_result = 32'h0000_0108; mem_read = 1'b1; funct3 = 3'b010;
        @(negedge clk);
        req_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst_n = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_idle: got req_ready=%b resp_valid=%b required 1 and 0", req_ready, resp_valid);
        end
        repeat (2) @(negedge clk);
        dmem_rvalid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_wait_late_rvalid: got resp_valid=%b req_ready=%b required 0 and 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_op("b2b_0", 32'h0000_0AA0, 32'h0, 5'd1, 1'b0, 1'b0, 3'b000, 0, 1, 32'h0, 0);
        do_op("b2b_1", 32'h0000_0AA2, 32'h0, 5'd2, 1'b1, 1'b0, 3'b001, 0, 1, 32'h00F0_8000, 0);
        do_op("b2b_2", 32'h0000_0AA1, 32'h9C, 5'd3, 1'b0, 1'b1, 3'b000, 0, 1, 32'h0, 0);
    endtask

    task automatic test_random();
        logic [2:0]  f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [31:0] a;
        logic [2:0]  f3;
        int          kind, gd, rv;
        for (int n = 0; n < 40; n++) begin
            f3   = f3_tab[$urandom_range(0, 4)];
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1])      a[1:0] = 2'b00;
                else if (f3[0]) a[0]   = 1'b0;
            end
            kind = $urandom_range(0, 3);
            gd   = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 4);
            rv   = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(1, 4);
            do_op($sformatf("rand%0d", n), a, $urandom, 5'($urandom_range(0, 31)),
                  kind == 1 || kind == 3, kind == 2 || kind == 3, f3, gd, rv, $urandom,
                  $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_in_flight();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion before 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
